id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the RISC-V core.
- Latches decoded operands and control from ID, applies stall and flush, and detects load-use hazards.
- Resolves operand forwarding from EX/MEM and MEM/WB.
- Drives the ALU's DATA1, DATA2 and 5-bit SELECT directly.

## Interface
Parameters:
- XLEN, 32, datapath width
- NOP_SELECT, 5'b00000, ALU SELECT driven while the stage holds a bubble (ADD)

Ports (name, direction, width, meaning):
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- STALL  in  1  hold all stage registers
- FLUSH  in  1  replace stage contents with a bubble
- VALID_IN  in  1  ID holds a real instruction
- PC_IN, DATA1_IN, DATA2_IN, IMM_IN  in  XLEN  PC, register-file reads rs1/rs2, immediate
- RS1_IN, RS2_IN, RD_IN  in  5  register indices
- USE_RS1_IN, USE_RS2_IN  in  1  instruction reads rs1/rs2
- ALU_SELECT_IN  in  5  ALU operation code
- OP1_PC_IN  in  1  DATA1 takes PC instead of rs1
- OP2_IMM_IN  in  1  DATA2 takes immediate instead of rs2
- MEM_READ_IN, MEM_WRITE_IN, REG_WRITE_IN  in  1  downstream control
- EXMEM_RD, MEMWB_RD  in  5  destination of the older instructions
- EXMEM_REG_WRITE, MEMWB_REG_WRITE  in  1  older instruction writes a register
- EXMEM_RESULT, MEMWB_RESULT  in  XLEN  forwardable values
- DATA1, DATA2  out  XLEN  ALU operands
- SELECT  out  5  ALU operation
- STORE_DATA  out  XLEN  forwarded rs2 for stores
- PC_OUT  out  XLEN  latched PC
- RD_OUT  out  5  latched destination register
- VALID_OUT, MEM_READ_OUT, MEM_WRITE_OUT, REG_WRITE_OUT  out  1  latched control
- LOAD_USE_STALL  out  1  to hazard unit; freezes PC and IF/ID

## Operation
- Stage register update priority at each rising edge: RESET, then FLUSH, then STALL, then LOAD_USE_STALL, then normal load.
- Bubble: VALID_OUT, MEM_READ_OUT, MEM_WRITE_OUT and REG_WRITE_OUT are 0, RD_OUT is 0, SELECT is NOP_SELECT, and data fields are 0.
- Normal load captures all *_IN fields. When capturing rs1 or rs2: if MEMWB_REG_WRITE is set, MEMWB_RD equals RS*_IN, and MEMWB_RD is nonzero, capture MEMWB_RESULT instead of DATA*_IN. This covers a register file that returns the old value on a same-cycle write.
- STALL hold: all fields keep their values, except the latched rs1/rs2 values. Each latched value is refreshed from MEMWB_RESULT when MEMWB writes a matching nonzero register, so a writeback that retires during the stall is not lost.
- Forwarding (combinational, after the register), per operand:
  - EX/MEM match (REG_WRITE set, RD equals the latched rs, RD nonzero) selects EXMEM_RESULT.
  - Otherwise a MEM/WB match selects MEMWB_RESULT.
  - Otherwise the latched value is used.
  - Register x0 is never forwarded.
- DATA1 is PC_OUT when OP1_PC is set, otherwise forwarded rs1.
- DATA2 is the immediate when OP2_IMM is set, otherwise forwarded rs2.
- STORE_DATA is always forwarded rs2.
- LOAD_USE_STALL is 1 when all of the following hold:
  - VALID_OUT, MEM_READ_OUT and VALID_IN are set;
  - RD_OUT is nonzero;
  - RD_OUT equals RS1_IN with USE_RS1_IN set, or RD_OUT equals RS2_IN with USE_RS2_IN set.
  - On that edge the stage loads a bubble; upstream holds.

## Timing
- Reset (asynchronous, RESET low): every output register goes to the bubble state and PC_OUT is 0. DATA1, DATA2 and STORE_DATA therefore read 0, and LOAD_USE_STALL reads 0.
- Latency: one cycle from ID inputs to outputs. Forwarding and LOAD_USE_STALL are same-cycle combinational paths.
- FLUSH together with STALL: the bubble is loaded (flush wins).
- STALL together with LOAD_USE_STALL: hold (no bubble); LOAD_USE_STALL remains asserted.
- A load-use stall costs exactly one bubble. Next cycle the load is in MEM and the dependent instruction loads and gets MEMWB_RESULT via capture or forwarding.
- RESET deasserting mid-stream: the first edge after release performs a normal load.

## Structure
- Shared package riscv_pkg:
  - ALU SELECT encodings (ADD 00000 through SLTU 10001);
  - XLEN;
  - REG_ZERO 5'd0;
  - a bubble constant for the control bundle.
- Sub-module operand_forward_mux, instantiated twice (rs1, rs2):
  - inputs: latched index and value plus both forwarding sources;
  - output: the resolved value.

## Test plan
- Reset mid-operation: drive valid ADD, assert RESET low between edges -> all outputs 0 immediately, VALID_OUT 0.
- EX/MEM priority: latched rs1=5; EXMEM_RD=5 with 0x11 and MEMWB_RD=5 with 0x22 -> DATA1 = 0x11. Repeat with RD=0 on both -> latched value.
- Load-use: lw x3 in stage, ID add using rs2=3 -> LOAD_USE_STALL = 1, next cycle VALID_OUT 0. The following cycle the add loads with DATA2 = the MEMWB load data.
- Stall refresh: latch rs1=7 as 0xAAAA, hold STALL 2 cycles with a MEMWB write of x7 = 0xBBBB in cycle 1 only -> DATA1 = 0xBBBB after STALL drops.
- FLUSH+STALL together -> bubble: SELECT 00000, REG_WRITE_OUT 0. Immediate op: OP2_IMM with IMM_IN 0xFFFFFFF0 and SELECT SLT -> DATA2 = 0xFFFFFFF0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the ID/EX pipeline stage and its helpers.
//   XLEN        default datapath width
//   REG_ZERO    index of the hard-wired zero register
//   alu_sel_e   5-bit ALU SELECT encodings (ADD 00000 .. SLTU 10001)
//   ctrl_t      latched control bundle, CTRL_BUBBLE is its empty value
//   wb_hits     true when a writing stage targets a given nonzero register
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_AND  = 5'b00010,
        ALU_OR   = 5'b00011,
        ALU_XOR  = 5'b00100,
        ALU_SLL  = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_SLT  = 5'b10000,
        ALU_SLTU = 5'b10001
    } alu_sel_e;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic op1_pc;
        logic op2_imm;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // x0 is never a real destination, so a write to it never matches.
    function automatic logic wb_hits(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
        return we && (rd == rs) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// operand_forward_mux: resolves one ALU source operand against the two
// older in-flight instructions. EX/MEM is younger than MEM/WB, so it wins.
//   rs_idx_i        latched source register index
//   rs_val_i        latched source register value
//   exmem_*_i       destination, write enable and result of EX/MEM
//   memwb_*_i       destination, write enable and result of MEM/WB
//   value_o         forwarded operand
module operand_forward_mux
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       rs_idx_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [4:0]       exmem_rd_i,
    input  logic             exmem_we_i,
    input  logic [WIDTH-1:0] exmem_result_i,
    input  logic [4:0]       memwb_rd_i,
    input  logic             memwb_we_i,
    input  logic [WIDTH-1:0] memwb_result_i,
    output logic [WIDTH-1:0] value_o
);

    always_comb begin
        value_o = rs_val_i;
        if (wb_hits(exmem_we_i, exmem_rd_i, rs_idx_i)) begin
            value_o = exmem_result_i;
        end else if (wb_hits(memwb_we_i, memwb_rd_i, rs_idx_i)) begin
            value_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID -> EX pipeline register with stall/flush handling,
// load-use hazard detection and operand forwarding into the ALU.
//   CLK, RESET (async, active low), STALL, FLUSH
//   *_IN            decoded instruction from ID
//   EXMEM_*, MEMWB_* older instructions available for forwarding
//   DATA1/DATA2/SELECT  ALU operands and operation
//   STORE_DATA      forwarded rs2 for stores
//   PC_OUT, RD_OUT, *_OUT  latched fields for downstream stages
//   LOAD_USE_STALL  freezes PC and IF/ID for one cycle
module id_ex_stage #(
    parameter int         XLEN       = riscv_pkg::XLEN,
    parameter logic [4:0] NOP_SELECT = 5'b00000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            VALID_IN,
    input  logic [XLEN-1:0] PC_IN,
    input  logic [XLEN-1:0] DATA1_IN,
    input  logic [XLEN-1:0] DATA2_IN,
    input  logic [XLEN-1:0] IMM_IN,
    input  logic [4:0]      RS1_IN,
    input  logic [4:0]      RS2_IN,
    input  logic [4:0]      RD_IN,
    input  logic            USE_RS1_IN,
    input  logic            USE_RS2_IN,
    input  logic [4:0]      ALU_SELECT_IN,
    input  logic            OP1_PC_IN,
    input  logic            OP2_IMM_IN,
    input  logic            MEM_READ_IN,
    input  logic            MEM_WRITE_IN,
    input  logic            REG_WRITE_IN,
    input  logic [4:0]      EXMEM_RD,
    input  logic [4:0]      MEMWB_RD,
    input  logic            EXMEM_REG_WRITE,
    input  logic            MEMWB_REG_WRITE,
    input  logic [XLEN-1:0] EXMEM_RESULT,
    input  logic [XLEN-1:0] MEMWB_RESULT,
    output logic [XLEN-1:0] DATA1,
    output logic [XLEN-1:0] DATA2,
    output logic [4:0]      SELECT,
    output logic [XLEN-1:0] STORE_DATA,
    output logic [XLEN-1:0] PC_OUT,
    output logic [4:0]      RD_OUT,
    output logic            VALID_OUT,
    output logic            MEM_READ_OUT,
    output logic            MEM_WRITE_OUT,
    output logic            REG_WRITE_OUT,
    output logic            LOAD_USE_STALL
);

    import riscv_pkg::ctrl_t;
    import riscv_pkg::CTRL_BUBBLE;
    import riscv_pkg::REG_ZERO;
    import riscv_pkg::wb_hits;

    ctrl_t           ctrl_q,    ctrl_d;
    logic [4:0]      sel_q,     sel_d;
    logic [4:0]      rd_q,      rd_d;
    logic [4:0]      rs1_q,     rs1_d;
    logic [4:0]      rs2_q,     rs2_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;

    logic            load_use;
    logic            take_bubble;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // A load in this stage whose destination the ID instruction reads
    // cannot be forwarded in time: its data only exists one cycle later.
    assign load_use = ctrl_q.valid && ctrl_q.mem_read && VALID_IN &&
                      (rd_q != REG_ZERO) &&
                      ((USE_RS1_IN && (rd_q == RS1_IN)) ||
                       (USE_RS2_IN && (rd_q == RS2_IN)));

    // FLUSH beats STALL; STALL beats the load-use bubble so a held
    // load stays put while the hazard output remains asserted.
    assign take_bubble = FLUSH || (!STALL && load_use);

    always_comb begin
        ctrl_d    = ctrl_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        if (take_bubble) begin
            ctrl_d    = CTRL_BUBBLE;
            sel_d     = NOP_SELECT;
            rd_d      = REG_ZERO;
            rs1_d     = REG_ZERO;
            rs2_d     = REG_ZERO;
            pc_d      = '0;
            imm_d     = '0;
            rs1_val_d = '0;
            rs2_val_d = '0;
        end else if (STALL) begin
            // A writeback retiring while we hold would otherwise be lost.
            if (wb_hits(MEMWB_REG_WRITE, MEMWB_RD, rs1_q)) rs1_val_d = MEMWB_RESULT;
            if (wb_hits(MEMWB_REG_WRITE, MEMWB_RD, rs2_q)) rs2_val_d = MEMWB_RESULT;
        end else begin
            ctrl_d.valid     = VALID_IN;
            ctrl_d.mem_read  = MEM_READ_IN;
            ctrl_d.mem_write = MEM_WRITE_IN;
            ctrl_d.reg_write = REG_WRITE_IN;
            ctrl_d.op1_pc    = OP1_PC_IN;
            ctrl_d.op2_imm   = OP2_IMM_IN;
            sel_d            = ALU_SELECT_IN;
            rd_d             = RD_IN;
            rs1_d            = RS1_IN;
            rs2_d            = RS2_IN;
            pc_d             = PC_IN;
            imm_d            = IMM_IN;
            // The register file returns the pre-write value on a
            // same-cycle write, so take the writeback data directly.
            rs1_val_d = wb_hits(MEMWB_REG_WRITE, MEMWB_RD, RS1_IN) ? MEMWB_RESULT : DATA1_IN;
            rs2_val_d = wb_hits(MEMWB_REG_WRITE, MEMWB_RD, RS2_IN) ? MEMWB_RESULT : DATA2_IN;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctrl_q    <= CTRL_BUBBLE;
            sel_q     <= NOP_SELECT;
            rd_q      <= REG_ZERO;
            rs1_q     <= REG_ZERO;
            rs2_q     <= REG_ZERO;
            pc_q      <= '0;
            imm_q     <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
        end
    end

    operand_forward_mux #(.WIDTH(XLEN)) u_fwd_rs1 (
        .rs_idx_i       (rs1_q),
        .rs_val_i       (rs1_val_q),
        .exmem_rd_i     (EXMEM_RD),
        .exmem_we_i     (EXMEM_REG_WRITE),
        .exmem_result_i (EXMEM_RESULT),
        .memwb_rd_i     (MEMWB_RD),
        .memwb_we_i     (MEMWB_REG_WRITE),
        .memwb_result_i (MEMWB_RESULT),
        .value_o        (rs1_fwd)
    );

    operand_forward_mux #(.WIDTH(XLEN)) u_fwd_rs2 (
        .rs_idx_i       (rs2_q),
        .rs_val_i       (rs2_val_q),
        .exmem_rd_i     (EXMEM_RD),
        .exmem_we_i     (EXMEM_REG_WRITE),
        .exmem_result_i (EXMEM_RESULT),
        .memwb_rd_i     (MEMWB_RD),
        .memwb_we_i     (MEMWB_REG_WRITE),
        .memwb_result_i (MEMWB_RESULT),
        .value_o        (rs2_fwd)
    );

    assign DATA1          = ctrl_q.op1_pc  ? pc_q  : rs1_fwd;
    assign DATA2          = ctrl_q.op2_imm ? imm_q : rs2_fwd;
    assign STORE_DATA     = rs2_fwd;
    assign SELECT         = sel_q;
    assign PC_OUT         = pc_q;
    assign RD_OUT         = rd_q;
    assign VALID_OUT      = ctrl_q.valid;
    assign MEM_READ_OUT   = ctrl_q.mem_read;
    assign MEM_WRITE_OUT  = ctrl_q.mem_write;
    assign REG_WRITE_OUT  = ctrl_q.reg_write;
    assign LOAD_USE_STALL = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, STALL, FLUSH, VALID_IN;
    logic [31:0] PC_IN, DATA1_IN, DATA2_IN, IMM_IN;
    logic [4:0]  RS1_IN, RS2_IN, RD_IN, ALU_SELECT_IN;
    logic        USE_RS1_IN, USE_RS2_IN, OP1_PC_IN, OP2_IMM_IN;
    logic        MEM_READ_IN, MEM_WRITE_IN, REG_WRITE_IN;
    logic [4:0]  EXMEM_RD, MEMWB_RD;
    logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE;
    logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
    logic [31:0] DATA1, DATA2, STORE_DATA, PC_OUT;
    logic [4:0]  SELECT, RD_OUT;
    logic        VALID_OUT, MEM_READ_OUT, MEM_WRITE_OUT, REG_WRITE_OUT, LOAD_USE_STALL;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    id_ex_stage #(.XLEN(32), .NOP_SELECT(5'b00000)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .VALID_IN(VALID_IN),
        .PC_IN(PC_IN), .DATA1_IN(DATA1_IN), .DATA2_IN(DATA2_IN), .IMM_IN(IMM_IN),
        .RS1_IN(RS1_IN), .RS2_IN(RS2_IN), .RD_IN(RD_IN),
        .USE_RS1_IN(USE_RS1_IN), .USE_RS2_IN(USE_RS2_IN),
        .ALU_SELECT_IN(ALU_SELECT_IN), .OP1_PC_IN(OP1_PC_IN), .OP2_IMM_IN(OP2_IMM_IN),
        .MEM_READ_IN(MEM_READ_IN), .MEM_WRITE_IN(MEM_WRITE_IN), .REG_WRITE_IN(REG_WRITE_IN),
        .EXMEM_RD(EXMEM_RD), .MEMWB_RD(MEMWB_RD),
        .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .MEMWB_REG_WRITE(MEMWB_REG_WRITE),
        .EXMEM_RESULT(EXMEM_RESULT), .MEMWB_RESULT(MEMWB_RESULT),
        .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .STORE_DATA(STORE_DATA),
        .PC_OUT(PC_OUT), .RD_OUT(RD_OUT), .VALID_OUT(VALID_OUT),
        .MEM_READ_OUT(MEM_READ_OUT), .MEM_WRITE_OUT(MEM_WRITE_OUT),
        .REG_WRITE_OUT(REG_WRITE_OUT), .LOAD_USE_STALL(LOAD_USE_STALL)
    );

    typedef struct {
        string       name;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd, sel;
        logic        op1pc, op2imm;
        logic [4:0]  exrd;
        logic        exwe;
        logic [31:0] exres;
        logic [4:0]  wbrd;
        logic        wbwe;
        logic [31:0] wbres;
        logic [31:0] e_d1, e_d2, e_st;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic clear_inputs();
        STALL = 0; FLUSH = 0; VALID_IN = 0;
        PC_IN = 0; DATA1_IN = 0; DATA2_IN = 0; IMM_IN = 0;
        RS1_IN = 0; RS2_IN = 0; RD_IN = 0; ALU_SELECT_IN = 0;
        USE_RS1_IN = 0; USE_RS2_IN = 0; OP1_PC_IN = 0; OP2_IMM_IN = 0;
        MEM_READ_IN = 0; MEM_WRITE_IN = 0; REG_WRITE_IN = 0;
        EXMEM_RD = 0; MEMWB_RD = 0; EXMEM_REG_WRITE = 0; MEMWB_REG_WRITE = 0;
        EXMEM_RESULT = 0; MEMWB_RESULT = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        clear_inputs();
        VALID_IN = 1; REG_WRITE_IN = 1;
        PC_IN = v.pc; DATA1_IN = v.d1; DATA2_IN = v.d2; IMM_IN = v.imm;
        RS1_IN = v.rs1; RS2_IN = v.rs2; RD_IN = v.rd; ALU_SELECT_IN = v.sel;
        OP1_PC_IN = v.op1pc; OP2_IMM_IN = v.op2imm;
        EXMEM_RD = v.exrd; EXMEM_REG_WRITE = v.exwe; EXMEM_RESULT = v.exres;
        MEMWB_RD = v.wbrd; MEMWB_REG_WRITE = v.wbwe; MEMWB_RESULT = v.wbres;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //               name            pc        d1        d2        imm          rs1 rs2 rd  sel       op1 op2 exrd we exres        wbrd we wbres        e_d1         e_d2         e_st
        vecs[0] = '{"add_plain",    32'h100,  32'h10,   32'h20,   32'h0,        1,  2,  3, ALU_ADD,  0, 0,  0, 0, 32'h0,       0, 0, 32'h0,       32'h10,      32'h20,      32'h20};
        vecs[1] = '{"exmem_prio",   32'h104,  32'h55,   32'h66,   32'h0,        5,  6,  4, ALU_ADD,  0, 0,  5, 1, 32'h11,      5, 1, 32'h22,      32'h11,      32'h66,      32'h66};
        vecs[2] = '{"rd_zero",      32'h108,  32'h55,   32'h66,   32'h0,        5,  6,  4, ALU_ADD,  0, 0,  0, 1, 32'h11,      0, 1, 32'h22,      32'h55,      32'h66,      32'h66};
        vecs[3] = '{"memwb_fwd",    32'h10c,  32'h70,   32'h80,   32'h0,        7,  8,  9, ALU_SUB,  0, 0,  9, 1, 32'h99,      8, 1, 32'h88,      32'h70,      32'h88,      32'h88};
        vecs[4] = '{"imm_slt",      32'h110,  32'h3,    32'h4,    32'hFFFFFFF0, 1,  2,  5, ALU_SLT,  0, 1,  0, 0, 32'h0,       0, 0, 32'h0,       32'h3,       32'hFFFFFFF0, 32'h4};
        vecs[5] = '{"pc_imm",       32'h2000, 32'h0,    32'h0,    32'h1000,     0,  0,  6, ALU_ADD,  1, 1,  0, 1, 32'h77,      0, 1, 32'h66,      32'h2000,    32'h1000,    32'h0};
        vecs[6] = '{"we_off",       32'h118,  32'h44,   32'h45,   32'h0,        4,  4,  7, ALU_AND,  0, 0,  4, 0, 32'h11,      4, 0, 32'h22,      32'h44,      32'h45,      32'h45};
        vecs[7] = '{"both_src",     32'h11c,  32'h1,    32'h2,    32'h0,       10, 10, 11, ALU_OR,   0, 0, 10, 1, 32'hDEAD,   10, 1, 32'hBEEF,    32'hDEAD,    32'hDEAD,    32'hDEAD};

        clear_inputs();
        RESET = 0;
        #2;
        $display("reset: VALID_OUT=%b SELECT=%h DATA1=%h", VALID_OUT, SELECT, DATA1);
        check("reset_valid", {31'd0, VALID_OUT}, 32'd0);
        check("reset_select", {27'd0, SELECT}, 32'd0);
        check("reset_data1", DATA1, 32'd0);
        check("reset_data2", DATA2, 32'd0);
        check("reset_pc", PC_OUT, 32'd0);
        check("reset_lus", {31'd0, LOAD_USE_STALL}, 32'd0);
        @(negedge CLK);
        RESET = 1;

        for (int i = 0; i < 8; i++) begin
            drive_vec(vecs[i]);
            tick();
            $display("vec %s: DATA1=%h DATA2=%h STORE=%h SELECT=%h", vecs[i].name, DATA1, DATA2, STORE_DATA, SELECT);
            check({vecs[i].name, "_data1"}, DATA1, vecs[i].e_d1);
            check({vecs[i].name, "_data2"}, DATA2, vecs[i].e_d2);
            check({vecs[i].name, "_store"}, STORE_DATA, vecs[i].e_st);
            check({vecs[i].name, "_select"}, {27'd0, SELECT}, {27'd0, vecs[i].sel});
            check({vecs[i].name, "_rd"}, {27'd0, RD_OUT}, {27'd0, vecs[i].rd});
            check({vecs[i].name, "_pc"}, PC_OUT, vecs[i].pc);
            check({vecs[i].name, "_valid"}, {31'd0, VALID_OUT}, 32'd1);
            check({vecs[i].name, "_lus"}, {31'd0, LOAD_USE_STALL}, 32'd0);
        end

        // Reset asserted between edges clears outputs immediately.
        drive_vec(vecs[0]);
        tick();
        check("rst_mid_pre_valid", {31'd0, VALID_OUT}, 32'd1);
        @(negedge CLK);
        RESET = 0;
        #1;
        $display("reset mid: VALID_OUT=%b DATA1=%h PC_OUT=%h", VALID_OUT, DATA1, PC_OUT);
        check("rst_mid_valid", {31'd0, VALID_OUT}, 32'd0);
        check("rst_mid_data1", DATA1, 32'd0);
        check("rst_mid_data2", DATA2, 32'd0);
        check("rst_mid_store", STORE_DATA, 32'd0);
        check("rst_mid_pc", PC_OUT, 32'd0);
        check("rst_mid_regwrite", {31'd0, REG_WRITE_OUT}, 32'd0);
        @(negedge CLK);
        RESET = 1;
        tick();
        $display("reset release: VALID_OUT=%b DATA1=%h", VALID_OUT, DATA1);
        check("rst_release_valid", {31'd0, VALID_OUT}, 32'd1);
        check("rst_release_data1", DATA1, 32'h10);

        // Load-use: lw x3 in stage, add reading x3 in ID.
        clear_inputs();
        VALID_IN = 1; MEM_READ_IN = 1; REG_WRITE_IN = 1; RD_IN = 3;
        RS1_IN = 1; DATA1_IN = 32'h1000; OP2_IMM_IN = 1; IMM_IN = 4;
        tick();
        clear_inputs();
        VALID_IN = 1; REG_WRITE_IN = 1; RD_IN = 4; ALU_SELECT_IN = ALU_ADD;
        RS1_IN = 1; RS2_IN = 3; USE_RS1_IN = 1; USE_RS2_IN = 1;
        DATA1_IN = 32'h5; DATA2_IN = 32'h0;
        #1;
        $display("load-use detect: LOAD_USE_STALL=%b", LOAD_USE_STALL);
        check("lu_detect", {31'd0, LOAD_USE_STALL}, 32'd1);
        tick();
        $display("load-use bubble: VALID_OUT=%b LOAD_USE_STALL=%b", VALID_OUT, LOAD_USE_STALL);
        check("lu_bubble_valid", {31'd0, VALID_OUT}, 32'd0);
        check("lu_bubble_lus", {31'd0, LOAD_USE_STALL}, 32'd0);
        MEMWB_RD = 3; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 32'hCAFE;
        tick();
        MEMWB_REG_WRITE = 0; MEMWB_RESULT = 0;
        #1;
        $display("load-use dependent: VALID_OUT=%b DATA2=%h", VALID_OUT, DATA2);
        check("lu_dep_valid", {31'd0, VALID_OUT}, 32'd1);
        check("lu_dep_data2", DATA2, 32'hCAFE);
        check("lu_dep_data1", DATA1, 32'h5);

        // STALL with a load-use hazard holds the load instead of bubbling.
        clear_inputs();
        VALID_IN = 1; MEM_READ_IN = 1; REG_WRITE_IN = 1; RD_IN = 3;
        tick();
        clear_inputs();
        VALID_IN = 1; RS1_IN = 3; USE_RS1_IN = 1; RD_IN = 4; STALL = 1;
        #1;
        check("stall_lu_detect", {31'd0, LOAD_USE_STALL}, 32'd1);
        tick();
        $display("stall+load-use: VALID_OUT=%b MEM_READ_OUT=%b LUS=%b", VALID_OUT, MEM_READ_OUT, LOAD_USE_STALL);
        check("stall_lu_valid", {31'd0, VALID_OUT}, 32'd1);
        check("stall_lu_memread", {31'd0, MEM_READ_OUT}, 32'd1);
        check("stall_lu_lus", {31'd0, LOAD_USE_STALL}, 32'd1);

        // Stall refresh: writeback of x7 during the stall reaches DATA1.
        clear_inputs();
        VALID_IN = 1; RS1_IN = 7; DATA1_IN = 32'hAAAA; RD_IN = 8; REG_WRITE_IN = 1;
        tick();
        check("refresh_initial", DATA1, 32'hAAAA);
        STALL = 1; MEMWB_RD = 7; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 32'hBBBB;
        tick();
        MEMWB_REG_WRITE = 0; MEMWB_RESULT = 0;
        tick();
        STALL = 0; VALID_IN = 0;
        #1;
        $display("stall refresh: DATA1=%h VALID_OUT=%b", DATA1, VALID_OUT);
        check("refresh_data1", DATA1, 32'hBBBB);
        check("refresh_valid", {31'd0, VALID_OUT}, 32'd1);

        // FLUSH together with STALL loads a bubble.
        clear_inputs();
        VALID_IN = 1; REG_WRITE_IN = 1; RD_IN = 5; ALU_SELECT_IN = ALU_SUB;
        tick();
        check("flush_pre_select", {27'd0, SELECT}, {27'd0, ALU_SUB});
        FLUSH = 1; STALL = 1;
        tick();
        $display("flush+stall: SELECT=%h REG_WRITE_OUT=%b VALID_OUT=%b", SELECT, REG_WRITE_OUT, VALID_OUT);
        check("flush_select", {27'd0, SELECT}, 32'd0);
        check("flush_regwrite", {31'd0, REG_WRITE_OUT}, 32'd0);
        check("flush_valid", {31'd0, VALID_OUT}, 32'd0);
        check("flush_rd", {27'd0, RD_OUT}, 32'd0);
        clear_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
